// File: rtl/rv_core_pkg.sv
// Shared core definitions: architectural width, reset vector and the fetch queue entry type.
package rv_core_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetched {instruction, pc} pairs with flush; the head output holds
// the last presented entry while the queue is empty so decode never sees X.
module fetch_queue
  import rv_core_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [QDEPTH];
  fetch_entry_t  hold;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          empty;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(QDEPTH));
  assign pop_ok  = pop & ~empty & ~flush;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & ~flush & (~full | pop_ok);

  assign head = empty ? hold : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (!empty) begin
        hold <= mem[rd_ptr];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop_ok) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push_ok) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, captures same-cycle memory read data into the fetch
// queue and hands instructions to decode; a redirect flushes the queue and reloads the PC.
module instruction_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2,
  localparam int         CW       = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_en,
  output logic [31:0]   imem_addr,
  output logic          imem_req,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr_data,
  output logic [31:0]   instr_pc,
  output logic [CW-1:0] q_count
);

  logic [31:0]  pc;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign instr_valid = (q_count != '0);
  assign pop         = instr_valid & instr_ready;
  // Capture is suppressed while reset is held so no word is taken from a stale address.
  assign imem_req    = ~rst & fetch_en & ~redirect_valid &
                       ((q_count < CW'(QDEPTH)) | pop);

  assign imem_addr   = pc;
  assign push_entry  = '{instr: imem_rdata, pc: pc};
  assign instr_data  = head.instr;
  assign instr_pc    = head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (imem_req) begin
      pc <= pc + 32'd4;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (imem_req),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (q_count)
  );

endmodule
